// File: rtl/mem_source_sequencer.sv
// rtl/mem_source_sequencer.sv - ROM-then-buffer word sequencer with 2-entry tagged output FIFO
module mem_source_sequencer #(
    parameter int BIT_WIDTH   = 32,
    parameter int EXTRA_BIT   = 2,
    parameter int NUM_BUFFERS = 2,
    parameter int INIT_DEPTH  = 16,
    parameter int ADDR_WIDTH  = 4,
    parameter int SEL_WIDTH   = 1
) (
    input  logic                                         CLK,
    input  logic                                         RST_N,
    input  logic                                         START,
    input  logic                                         STOP,
    input  logic [SEL_WIDTH-1:0]                         BUF_SEL,
    output logic                                         ROM_RD_EN,
    output logic [ADDR_WIDTH-1:0]                        ROM_ADDR,
    input  logic [BIT_WIDTH+EXTRA_BIT-1:0]               ROM_OUTPUT,
    input  logic [NUM_BUFFERS*(BIT_WIDTH+EXTRA_BIT)-1:0] BUFFER_OUTPUT,
    input  logic [NUM_BUFFERS-1:0]                       BUFFER_VALID,
    output logic [NUM_BUFFERS-1:0]                       BUFFER_READY,
    output logic [BIT_WIDTH+EXTRA_BIT-1:0]               SCALAR_OUTPUT,
    output logic                                         SCALAR_VALID,
    input  logic                                         SCALAR_READY,
    output logic                                         SCALAR_SRC,
    output logic                                         INITIAL_ROM_READ_FLAG,
    output logic                                         BUSY,
    output logic                                         DONE,
    output logic                                         SEL_ERR
);

    localparam int W = BIT_WIDTH + EXTRA_BIT;
    // Address counter is one bit wider so it can reach INIT_DEPTH == 2^ADDR_WIDTH.
    localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(INIT_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ROM_FILL = 2'd1,
        S_RUN      = 2'd2,
        S_DRAIN    = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   addr_q, addr_d;
    logic                  inflight_q, inflight_d;
    logic                  pending_q, pending_d;
    logic                  sel_err_q, sel_err_d;
    logic                  done_q, done_d;
    logic [1:0]            count_q, count_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic [W-1:0]          data_q [2];
    logic [W-1:0]          data_d [2];
    logic                  src_q [2];
    logic                  src_d [2];

    logic [W-1:0]          sel_data;
    logic [NUM_BUFFERS-1:0] sel_onehot;
    logic                  sel_ok;
    logic                  pop;
    logic                  push;
    logic                  buf_push;
    logic [W-1:0]          push_data;
    logic [2:0]            occ;
    logic [2:0]            room_lim;
    logic                  rom_rd_en;
    logic [NUM_BUFFERS-1:0] buf_ready;

    // Decode BUF_SEL into a one-hot channel select and mux that channel's data.
    always_comb begin
        sel_data   = '0;
        sel_onehot = '0;
        for (int k = 0; k < NUM_BUFFERS; k++) begin
            if (BUF_SEL == SEL_WIDTH'(k)) begin
                sel_data      = BUFFER_OUTPUT[k*W +: W];
                sel_onehot[k] = 1'b1;
            end
        end
        sel_ok = |sel_onehot;
    end

    // Handshake and issue decisions; the pop this cycle frees a slot for a new issue.
    always_comb begin
        pop       = (count_q != 2'd0) && SCALAR_READY;
        occ       = {1'b0, count_q} + {2'b00, inflight_q};
        room_lim  = 3'd2 + {2'b00, pop};
        rom_rd_en = (state_q == S_ROM_FILL) && (addr_q < DEPTH) && (occ < room_lim);
        buf_ready = ((state_q == S_RUN) && !pending_q && ({1'b0, count_q} < room_lim))
                    ? sel_onehot : '0;
        buf_push  = |(buf_ready & BUFFER_VALID);
        // ROM data returning and buffer transfers never overlap: one is ROM_FILL, the other RUN.
        push      = inflight_q || buf_push;
        push_data = inflight_q ? ROM_OUTPUT : sel_data;
    end

    // Next-state for the sequencing FSM and the 2-entry output FIFO.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        inflight_d = rom_rd_en;
        pending_d  = pending_q;
        sel_err_d  = sel_err_q;
        done_d     = 1'b0;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        data_d     = data_q;
        src_d      = src_q;
        count_d    = count_q + {1'b0, push} - {1'b0, pop};

        if (push) begin
            data_d[wr_ptr_q] = push_data;
            src_d[wr_ptr_q]  = inflight_q;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    sel_err_d = 1'b0;
                    addr_d    = '0;
                    pending_d = 1'b0;
                    state_d   = (INIT_DEPTH > 0) ? S_ROM_FILL : S_RUN;
                end
            end
            S_ROM_FILL: begin
                if (rom_rd_en) begin
                    addr_d = addr_q + 1'b1;
                end
                if (STOP) begin
                    pending_d = 1'b1;
                end
                // All reads issued; the last in-flight word lands in the FIFO on this edge.
                if (addr_q == DEPTH) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!sel_ok) begin
                    sel_err_d = 1'b1;
                end
                if (STOP || pending_q) begin
                    pending_d = 1'b0;
                    state_d   = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (count_q == 2'd0) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            inflight_q <= 1'b0;
            pending_q  <= 1'b0;
            sel_err_q  <= 1'b0;
            done_q     <= 1'b0;
            count_q    <= 2'd0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                src_q[i]  <= 1'b0;
            end
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            inflight_q <= inflight_d;
            pending_q  <= pending_d;
            sel_err_q  <= sel_err_d;
            done_q     <= done_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            data_q     <= data_d;
            src_q      <= src_d;
        end
    end

    assign ROM_RD_EN             = rom_rd_en;
    assign ROM_ADDR              = addr_q[ADDR_WIDTH-1:0];
    assign BUFFER_READY          = buf_ready;
    assign SCALAR_OUTPUT         = data_q[rd_ptr_q];
    assign SCALAR_SRC            = src_q[rd_ptr_q];
    assign SCALAR_VALID          = (count_q != 2'd0);
    assign INITIAL_ROM_READ_FLAG = (state_q == S_ROM_FILL);
    assign BUSY                  = (state_q != S_IDLE);
    assign DONE                  = done_q;
    assign SEL_ERR               = sel_err_q;

endmodule

// File: doc/mem_source_sequencer.md
Name: mem_source_sequencer

Overview:
- Parametrised successor of the scalar ROM/buffer read mux.
- On START it streams INIT_DEPTH initial words from ROM, then hands over automatically to one of NUM_BUFFERS RAM buffers, chosen at run time.
- Output is registered through a 2-entry output FIFO with a valid/ready handshake and a source tag.
- Sits between the initial-value ROM, the RAM buffer bank and the scalar datapath consumer.

Parameters:
- BIT_WIDTH, 32, data word width.
- EXTRA_BIT, 2, extra tag/guard bits per word; word width W = BIT_WIDTH+EXTRA_BIT.
- NUM_BUFFERS, 2, number of RAM buffer channels (minimum 1).
- INIT_DEPTH, 16, number of ROM words read per START; 0 is legal.
- ADDR_WIDTH, 4, ROM address width; INIT_DEPTH must not exceed 2^ADDR_WIDTH.
- SEL_WIDTH, 1, width of BUF_SEL; 2^SEL_WIDTH must be at least NUM_BUFFERS.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST_N  in  1  synchronous active-low reset.
- START  in  1  one-cycle pulse; begins a sequence when in IDLE, ignored otherwise.
- STOP  in  1  ends buffer streaming (see Behaviour).
- BUF_SEL  in  SEL_WIDTH  selects the active buffer channel; sampled every cycle.
- ROM_RD_EN  out  1  ROM read strobe.
- ROM_ADDR  out  ADDR_WIDTH  ROM read address.
- ROM_OUTPUT  in  W  ROM data, valid exactly 1 cycle after ROM_RD_EN.
- BUFFER_OUTPUT  in  NUM_BUFFERS*W  flat buffer data; channel k is at bits [k*W +: W].
- BUFFER_VALID  in  NUM_BUFFERS  per-channel data valid.
- BUFFER_READY  out  NUM_BUFFERS  per-channel ready; one-hot or zero.
- SCALAR_OUTPUT  out  W  head word of the output FIFO.
- SCALAR_VALID  out  1  FIFO not empty.
- SCALAR_READY  in  1  consumer accepts the head word.
- SCALAR_SRC  out  1  source tag of the head word: 1 = ROM, 0 = buffer.
- INITIAL_ROM_READ_FLAG  out  1  high while the FSM is in ROM_FILL.
- BUSY  out  1  high whenever the FSM is not in IDLE.
- DONE  out  1  one-cycle pulse on DRAIN->IDLE.
- SEL_ERR  out  1  sticky flag: BUF_SEL >= NUM_BUFFERS was seen in RUN. Cleared by reset or START.

Behaviour:
- Reset (RST_N low at a clock edge):
  - FSM goes to IDLE; FIFO is emptied; in-flight ROM read is discarded.
  - ROM_ADDR counter returns to 0; pending-stop flag is cleared.
  - All outputs are 0, including SCALAR_OUTPUT.
  - Reset has priority over every other input, including mid-sequence.
- FSM states: IDLE, ROM_FILL, RUN, DRAIN.
  - IDLE: START -> ROM_FILL if INIT_DEPTH > 0, else -> RUN. START also clears SEL_ERR and the address counter.
  - ROM_FILL: issue reads for addresses 0..INIT_DEPTH-1 in order. After the last read has been issued and its data pushed into the FIFO, go to RUN.
  - RUN: forward words from the channel selected by BUF_SEL. STOP, or a pending stop, -> DRAIN.
  - DRAIN: no new reads and no BUFFER_READY. When the FIFO is empty, pulse DONE and go to IDLE.
- STOP during ROM_FILL sets a pending-stop flag. On entry to RUN the FSM goes to DRAIN on the following cycle, with no buffer transfer in between. STOP in IDLE or DRAIN is ignored.
- FIFO:
  - 2 entries, each holding W bits plus the source bit.
  - Pop occurs when SCALAR_VALID && SCALAR_READY.
  - Push and pop in the same cycle are both legal; the FIFO never overflows.
- ROM issue rule: ROM_RD_EN = in ROM_FILL && addr < INIT_DEPTH && (count + inflight - pop) < 2.
  - ROM_ADDR = current counter value; the counter increments on each issued read.
  - ROM_OUTPUT is pushed 1 cycle after ROM_RD_EN, tagged SRC=1.
- Buffer rule: in RUN with BUF_SEL < NUM_BUFFERS, BUFFER_READY[BUF_SEL] = (count - pop) < 2. All other ready bits are 0.
  - A transfer happens when VALID && READY on the selected channel; the word is pushed that cycle, tagged SRC=0.
  - BUF_SEL may change on any cycle. Only the selected channel is acknowledged.
- If BUF_SEL >= NUM_BUFFERS in RUN: all ready bits are 0, nothing is pushed, and SEL_ERR is set.
- Latency:
  - START at cycle t: ROM_RD_EN at t+1, first SCALAR_VALID at t+3.
  - Buffer handshake at t: SCALAR_VALID at t+1 if the FIFO was empty.
  - Throughput is 1 word/cycle when SCALAR_READY is held high.
- Ordering: all ROM words precede all buffer words. Within each source, order is preserved.
- No word is lost or duplicated under any SCALAR_READY pattern.

Test Plan:
- INIT_DEPTH=4, ROM model returns addr*3, SCALAR_READY=1, START at cycle 0 -> ROM_RD_EN on cycles 1-4; SCALAR_OUTPUT 0,3,6,9 with SRC=1 on cycles 3-6; INITIAL_ROM_READ_FLAG falls after the last push.
- Same as above but SCALAR_READY=0 for cycles 3-10 -> exactly 2 reads issued, then ROM_RD_EN held low; after release, stream 0,3,6,9 arrives complete with no gaps beyond the stall.
- RUN with BUF_SEL=1, channel 1 presenting 0xA,0xB,0xC and channel 0 held valid -> outputs A,B,C with SRC=0; BUFFER_READY[0] never asserted.
- STOP asserted during ROM_FILL -> all 4 ROM words delivered, zero buffer transfers, DONE pulses once the FIFO is empty, BUSY drops with it.
- BUF_SEL=3 with NUM_BUFFERS=2 in RUN -> BUFFER_READY=0, no push, SEL_ERR=1 until the next START.
- RST_N low for one cycle at mid ROM_FILL with 1 word buffered and 1 read in flight -> next cycle FSM in IDLE, SCALAR_VALID=0; the late ROM data is not pushed.
